// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float format defaults and rounding-mode encodings
package fp_pkg;

    localparam int FP_EXP_W = 3;
    localparam int FP_SIG_W = 4;
    localparam int FP_CNT_W = 8;

    typedef enum logic [1:0] {
        RM_HALF_UP   = 2'b00,
        RM_NEAR_EVEN = 2'b01,
        RM_TO_ZERO   = 2'b10,
        RM_AWAY      = 2'b11
    } round_mode_e;

    // Increment decision on the magnitude; the sign never takes part.
    function automatic logic round_inc(input round_mode_e mode, input logic lsb,
                                       input logic round, input logic sticky);
        logic inc;
        inc = 1'b0;
        case (mode)
            RM_HALF_UP:   inc = round;
            RM_NEAR_EVEN: inc = round & (sticky | lsb);
            RM_TO_ZERO:   inc = 1'b0;
            RM_AWAY:      inc = round | sticky;
            default:      inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// rtl/fp_round_inc.sv - mode decode and significand increment with carry
module fp_round_inc
    import fp_pkg::*;
#(
    parameter int SIG_W = FP_SIG_W
) (
    input  logic [1:0]       mode,
    input  logic [SIG_W-1:0] sig,
    input  logic             round,
    input  logic             sticky,
    output logic [SIG_W:0]   sum,
    output logic             inexact
);

    logic inc;

    assign inc     = round_inc(round_mode_e'(mode), sig[0], round, sticky);
    // The extra top bit carries the overflow into stage 2 for normalisation.
    assign sum     = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    assign inexact = round | sticky;

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage valid/ready significand rounder with saturation count
module fp_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int SIG_W = FP_SIG_W,
    parameter int CNT_W = FP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    input  logic             in_round,
    input  logic             in_sticky,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig,
    output logic             out_sat,
    output logic             out_inexact,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_count
);

    logic             ready_en;
    logic             s1_valid;
    logic             s1_sign;
    logic             s1_inexact;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W:0]   s1_sum;
    logic             s2_valid;

    logic             s1_en;
    logic             s2_en;
    logic             in_fire;
    logic             out_fire;

    logic [SIG_W:0]   inc_sum;
    logic             inc_inexact;

    logic [EXP_W-1:0] nrm_exp;
    logic [SIG_W-1:0] nrm_sig;
    logic             nrm_sat;

    // ready_en keeps in_ready low during reset and for the first edge after it.
    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = ready_en && s1_en;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;

    fp_round_inc #(
        .SIG_W (SIG_W)
    ) u_inc (
        .mode    (in_mode),
        .sig     (in_sig),
        .round   (in_round),
        .sticky  (in_sticky),
        .sum     (inc_sum),
        .inexact (inc_inexact)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_inexact <= 1'b0;
            s1_exp     <= '0;
            s1_sum     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_sign    <= in_sign;
                s1_inexact <= inc_inexact;
                s1_exp     <= in_exp;
                s1_sum     <= inc_sum;
            end
        end
    end

    // A carry renormalises to 1.000..; at the top exponent it clamps to all-ones.
    always_comb begin
        nrm_exp = s1_exp;
        nrm_sig = s1_sum[SIG_W-1:0];
        nrm_sat = 1'b0;
        if (s1_sum[SIG_W]) begin
            if (&s1_exp) begin
                nrm_exp = '1;
                nrm_sig = '1;
                nrm_sat = 1'b1;
            end else begin
                nrm_exp = s1_exp + {{(EXP_W-1){1'b0}}, 1'b1};
                nrm_sig = {1'b1, {(SIG_W-1){1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_sig     <= '0;
            out_sat     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign    <= s1_sign;
                out_exp     <= nrm_exp;
                out_sig     <= nrm_sig;
                out_sat     <= nrm_sat;
                out_inexact <= s1_inexact;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (clr_cnt) begin
            sat_count <= '0;
        end else if (out_fire && out_sat && !(&sat_count)) begin
            sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - scoreboard bench for fp_round_pipe
module tb_fp_round_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [2:0] in_exp;
    logic [3:0] in_sig;
    logic       in_round;
    logic       in_sticky;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [2:0] out_exp;
    logic [3:0] out_sig;
    logic       out_sat;
    logic       out_inexact;
    logic       clr_cnt;
    logic [7:0] sat_count;

    typedef struct packed {
        logic       sign;
        logic [2:0] exp;
        logic [3:0] sig;
        logic       sat;
        logic       inexact;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    beat_t mon_a;

    int checks      = 0;
    int failures    = 0;
    int n_acc       = 0;
    int total_waits = 0;

    logic [3:0] bp_in  [6] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    logic [3:0] bp_out [6] = '{4'b1000, 4'b1010, 4'b1010, 4'b1100, 4'b1100, 4'b1110};

    always #5 clk = ~clk;

    fp_round_pipe #(
        .EXP_W (3),
        .SIG_W (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_sig      (in_sig),
        .in_round    (in_round),
        .in_sticky   (in_sticky),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_sig     (out_sig),
        .out_sat     (out_sat),
        .out_inexact (out_inexact),
        .clr_cnt     (clr_cnt),
        .sat_count   (sat_count)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            mon_a = {out_sign, out_exp, out_sig, out_sat, out_inexact};
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got sign=%b exp=%b sig=%b sat=%b inexact=%b with nothing expected",
                         out_sign, out_exp, out_sig, out_sat, out_inexact);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL result: got sign=%b exp=%b sig=%b sat=%b inexact=%b expected sign=%b exp=%b sig=%b sat=%b inexact=%b",
                             mon_a.sign, mon_a.exp, mon_a.sig, mon_a.sat, mon_a.inexact,
                             mon_e.sign, mon_e.exp, mon_e.sig, mon_e.sat, mon_e.inexact);
                end
            end
        end
    end

    task automatic send(input logic [1:0] mode, input logic sign, input logic [2:0] e,
                        input logic [3:0] s, input logic r, input logic st,
                        input logic [2:0] xe, input logic [3:0] xs, input logic xsat);
        int    waits;
        bit    got;
        beat_t b;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_sign   = sign;
        in_exp    = e;
        in_sig    = s;
        in_round  = r;
        in_sticky = st;
        waits = 0;
        got   = 1'b0;
        while (!got && waits <= 200) begin
            @(negedge clk);
            if (in_ready) begin
                b.sign    = sign;
                b.exp     = xe;
                b.sig     = xs;
                b.sat     = xsat;
                b.inexact = r | st;
                sb.push_back(b);
                got = 1'b1;
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (!got) begin
                waits++;
                total_waits++;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no in_ready within %0d cycles", waits);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sig    = '0;
        in_round  = 1'b0;
        in_sticky = 1'b0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_sat_count", int'(sat_count), 0);
        chk("reset_out_fields", int'({out_sign, out_exp, out_sig, out_sat, out_inexact}), 0);
        rst = 1'b0;
        chk("in_ready_at_deassert", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        // Directed vectors, mode changing every beat, no bubbles expected.
        send(2'b00, 1'b0, 3'd3, 4'b1010, 1'b1, 1'b0, 3'd3, 4'b1011, 1'b0);
        send(2'b01, 1'b0, 3'd2, 4'b1010, 1'b1, 1'b0, 3'd2, 4'b1010, 1'b0);
        send(2'b01, 1'b0, 3'd2, 4'b1011, 1'b1, 1'b0, 3'd2, 4'b1100, 1'b0);
        send(2'b01, 1'b0, 3'd2, 4'b1010, 1'b1, 1'b1, 3'd2, 4'b1011, 1'b0);
        send(2'b00, 1'b0, 3'd4, 4'b1111, 1'b1, 1'b0, 3'd5, 4'b1000, 1'b0);
        send(2'b00, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
        send(2'b10, 1'b0, 3'd1, 4'b1001, 1'b1, 1'b1, 3'd1, 4'b1001, 1'b0);
        send(2'b11, 1'b0, 3'd1, 4'b1001, 1'b0, 1'b1, 3'd1, 4'b1010, 1'b0);
        send(2'b10, 1'b0, 3'd7, 4'b1111, 1'b0, 1'b0, 3'd7, 4'b1111, 1'b0);
        send(2'b11, 1'b1, 3'd2, 4'b1100, 1'b1, 1'b0, 3'd2, 4'b1101, 1'b0);
        send(2'b00, 1'b1, 3'd2, 4'b1100, 1'b0, 1'b1, 3'd2, 4'b1100, 1'b0);
        send(2'b11, 1'b0, 3'd7, 4'b1111, 1'b0, 1'b1, 3'd7, 4'b1111, 1'b1);
        idle();
        drain();
        chk("sat_count_after_directed", int'(sat_count), 2);
        chk("stall_cycles_streaming", total_waits, 0);

        // Backpressure: only two beats fit while the output is blocked.
        out_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(2'b00, 1'b0, 3'd1, bp_in[i], logic'(i % 2), 1'b0, 3'd1, bp_out[i], 1'b0);
                end
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("bp_accepted", n_acc, 2);
                chk("bp_in_ready", int'(in_ready), 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_out_valid", int'(out_valid), 1);
                    chk("bp_out_sig_held", int'(out_sig), int'(sb[0].sig));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total_accepted", n_acc, 6);

        // Fill the counter to its ceiling and push past it.
        for (int i = 0; i < 253; i++) begin
            send(2'b00, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
        end
        idle();
        drain();
        chk("sat_count_at_max", int'(sat_count), 255);
        send(2'b00, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
        idle();
        drain();
        chk("sat_count_holds_max", int'(sat_count), 255);

        // Clear coincident with a saturated transfer.
        out_ready = 1'b0;
        send(2'b11, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b1, 3'd7, 4'b1111, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("clr_beat_waiting", int'(out_valid), 1);
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_wins", int'(sat_count), 0);
        chk("clr_beat_delivered", sb.size(), 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(2'b00, 1'b0, 3'd3, 4'b1010, 1'b1, 1'b0, 3'd3, 4'b1011, 1'b0);
        send(2'b00, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
        idle();
        @(posedge clk);
        #1;
        chk("inflight_out_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_reset_out_valid", int'(out_valid), 0);
        chk("mid_reset_in_ready", int'(in_ready), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_beat", int'(out_valid), 0);
        chk("sat_count_after_reset", int'(sat_count), 0);

        send(2'b01, 1'b0, 3'd5, 4'b0110, 1'b1, 1'b1, 3'd5, 4'b0111, 1'b0);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_round_pipe.md
Name: fp_round_pipe

Overview:
Parametrised, pipelined successor to the combinational significand rounder in the fixed-to-float converter path. Rounds an EXP_W/SIG_W float, supplied with a round bit and a sticky bit, using one of four run-time rounding modes. Returns the rounded result through a 2-stage valid/ready pipeline. Flags exponent saturation and counts saturation events for debug readout.

Parameters:
EXP_W, 3, exponent field width
SIG_W, 4, significand field width (explicit leading bit, normalised inputs)
CNT_W, 8, width of the saturation event counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input this cycle
in_sign  input  1  sign; passed through unchanged
in_exp  input  EXP_W  exponent
in_sig  input  SIG_W  significand
in_round  input  1  first bit below significand LSB
in_sticky  input  1  OR of all bits below in_round
in_mode  input  2  00 half-up, 01 nearest-even, 10 toward zero, 11 away from zero
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sign  output  1  result sign
out_exp  output  EXP_W  rounded exponent
out_sig  output  SIG_W  rounded significand
out_sat  output  1  result saturated (exponent overflow)
out_inexact  output  1  in_round|in_sticky was set
clr_cnt  input  1  synchronous clear of sat_count
sat_count  output  CNT_W  count of accepted saturated results; saturates at all-ones

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - all pipeline valid bits 0, so out_valid=0.
  - out_sign/out_exp/out_sig/out_sat/out_inexact = 0.
  - sat_count = 0.
  - in_ready = 1 one cycle after reset deasserts; in_ready is 0 while rst=1.
- Handshake:
  - Transfer occurs on the rising edge where valid&ready are both high.
  - Output data is held stable while out_valid=1 and out_ready=0.
  - in_ready = !s1_valid | !s2_valid | out_ready. This is a bubble-collapsing pipeline; it is combinational from out_ready.
  - Latency: 2 cycles from input acceptance to out_valid when not stalled. Throughput: 1 beat/cycle.
- Stage 1 (increment decision):
  - Computes inc from in_mode:
    - 00: inc = round.
    - 01: inc = round & (sticky | sig[0]).
    - 10: inc = 0.
    - 11: inc = round | sticky.
  - Registers sum = {1'b0, sig} + inc (SIG_W+1 bits), plus exp, sign and inexact.
- Stage 2 (normalise/saturate):
  - No carry out of sum: out_sig = sum[SIG_W-1:0], out_exp = exp.
  - Carry out: out_sig = 1 followed by SIG_W-1 zeros, out_exp = exp+1. The result is the correctly shifted carry, not sig>>1.
  - If exp was all-ones and a carry occurred: out_exp = all-ones, out_sig = all-ones, out_sat = 1.
  - Input all-ones exp/sig with inc=0 passes through with out_sat = 0.
- Modes 00/11 operate on magnitude; sign never affects the increment.
- sat_count:
  - Increments on each output transfer (out_valid & out_ready) with out_sat = 1.
  - Holds at all-ones.
  - If clr_cnt and an increment occur in the same cycle, clear wins and the result is 0.
- Reset mid-operation discards all in-flight beats immediately. No partial output is ever presented.
- in_mode is sampled with the beat. Mode may change every beat with no bubbles.

Decomposition:
- Shared package fp_pkg holds:
  - round-mode encodings RM_HALF_UP, RM_NEAR_EVEN, RM_TO_ZERO, RM_AWAY.
  - default EXP_W/SIG_W constants shared with the converter.
- One natural sub-module, fp_round_inc: combinational mode decode plus increment and carry (stage 1 logic). Pipeline registers, handshake and counter stay in the top.

Test Plan:
- Mode 00, exp=3 sig=1010 round=1 sticky=0 -> 2 cycles later exp=3 sig=1011, sat=0, inexact=1.
- Mode 01, sig=1010 round=1 sticky=0 -> sig=1010 (tie to even). Then sig=1011 round=1 sticky=0 -> sig=1100. Then sig=1010 round=1 sticky=1 -> sig=1011.
- Mode 00, exp=4 sig=1111 round=1 -> exp=5 sig=1000. Then exp=7 sig=1111 round=1 -> exp=7 sig=1111, sat=1, sat_count increments 0->1.
- Mode 10 with round=1 sticky=1 -> sig unchanged, inexact=1. Mode 11 with round=0 sticky=1 -> sig+1.
- Backpressure: stream 6 beats with out_ready held 0 -> in_ready drops after 2 accepted beats and output stays stable. Release out_ready -> all 6 delivered in order with no loss or duplication.
- Counter and reset checks:
  - sat_count at 255 with another sat beat -> stays 255.
  - clr_cnt coincident with a sat transfer -> 0.
  - rst asserted with 2 beats in flight -> out_valid=0 immediately and no stale beat after release.
